// File: rtl/csr_pkg.sv
// Shared CSR definitions for the trap sequencer: addresses, cause codes,
// status/enable bit positions and the sequencer state type.
package csr_pkg;

    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MIE     = 32'h0000_0304;
    localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

    localparam logic [31:0] CAUSE_ECALL     = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
    localparam logic [31:0] CAUSE_EXT_IRQ   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER_IRQ = 32'h8000_0007;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIE_MTIE     = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_MSTATUS,
        ST_W_MEPC,
        ST_W_MCAUSE,
        ST_JUMP_TRAP,
        ST_MRET_W_MSTATUS,
        ST_JUMP_MRET
    } trap_state_e;

    // mstatus on trap entry: save MIE into MPIE, then disable interrupts.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r               = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    // mstatus on mret: restore MIE from MPIE, then set MPIE.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r               = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// Trap/interrupt sequencer. Accepts ecall/ebreak/mret/enabled interrupts
// from the execute stage, stalls the pipeline, writes mstatus/mepc/mcause
// one per cycle through the shared CSR write port, then redirects fetch.
//
// Write-port handshake: the execute unit owns the port whenever
// exu_csr_we_i=1; in that cycle csr_we_o is held low and the sequencer
// stays in its current write state, retrying every cycle until the port is
// free. A write is complete in exactly the cycle csr_we_o=1.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter bit          VECTORED_EN   = 1'b1,
    parameter logic [31:0] RST_PC_UNUSED = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_addr_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic        ext_irq_i,
    input  logic        timer_irq_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic        exu_csr_we_i,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        hold_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o,
    output trap_state_e dbg_state_o
);

    trap_state_e state_q, state_d;
    logic [31:0] pc_q, cause_q, mtvec_q, mepc_q, mstatus_q;
    logic [31:0] cause_d;
    logic        take_trap, take_mret;
    logic        ext_en, timer_en;
    logic [31:0] trap_base, trap_target;

    assign dbg_state_o = state_q;

    assign ext_en   = ext_irq_i   & mstatus_i[MSTATUS_MIE] & mie_i[MIE_MEIE];
    assign timer_en = timer_irq_i & mstatus_i[MSTATUS_MIE] & mie_i[MIE_MTIE];

    // Only interrupts are vectored; exceptions always land on the base.
    assign trap_base   = {mtvec_q[31:2], 2'b00};
    assign trap_target = (VECTORED_EN && (mtvec_q[1:0] == 2'b01) && cause_q[31])
                       ? trap_base + {25'd0, cause_q[4:0], 2'b00}
                       : trap_base;

    // Next-state and output decode; addresses/data depend only on state
    // and latched values, exu_csr_we_i only gates the enable and advance.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        take_trap   = 1'b0;
        take_mret   = 1'b0;
        csr_we_o    = 1'b0;
        csr_waddr_o = 32'h0;
        csr_wdata_o = 32'h0;
        hold_o      = (state_q != ST_IDLE);
        jump_o      = 1'b0;
        jump_addr_o = RST_PC_UNUSED;
        case (state_q)
            ST_IDLE: begin
                if (inst_valid_i && !rst) begin
                    if (ecall_i) begin
                        take_trap = 1'b1;
                        cause_d   = CAUSE_ECALL;
                    end else if (ebreak_i) begin
                        take_trap = 1'b1;
                        cause_d   = CAUSE_EBREAK;
                    end else if (mret_i) begin
                        take_mret = 1'b1;
                    end else if (ext_en) begin
                        take_trap = 1'b1;
                        cause_d   = CAUSE_EXT_IRQ;
                    end else if (timer_en) begin
                        take_trap = 1'b1;
                        cause_d   = CAUSE_TIMER_IRQ;
                    end
                end
                if (take_trap) begin
                    state_d = ST_W_MSTATUS;
                    hold_o  = 1'b1;
                end else if (take_mret) begin
                    state_d = ST_MRET_W_MSTATUS;
                    hold_o  = 1'b1;
                end
            end
            ST_W_MSTATUS: begin
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = trap_mstatus(mstatus_q);
                csr_we_o    = !exu_csr_we_i;
                if (!exu_csr_we_i) state_d = ST_W_MEPC;
            end
            ST_W_MEPC: begin
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = pc_q;
                csr_we_o    = !exu_csr_we_i;
                if (!exu_csr_we_i) state_d = ST_W_MCAUSE;
            end
            ST_W_MCAUSE: begin
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = cause_q;
                csr_we_o    = !exu_csr_we_i;
                if (!exu_csr_we_i) state_d = ST_JUMP_TRAP;
            end
            ST_JUMP_TRAP: begin
                jump_o      = 1'b1;
                jump_addr_o = trap_target;
                state_d     = ST_IDLE;
            end
            ST_MRET_W_MSTATUS: begin
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mret_mstatus(mstatus_q);
                csr_we_o    = !exu_csr_we_i;
                if (!exu_csr_we_i) state_d = ST_JUMP_MRET;
            end
            ST_JUMP_MRET: begin
                jump_o      = 1'b1;
                jump_addr_o = mepc_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and event snapshot taken in the accept cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= 32'h0;
            cause_q   <= 32'h0;
            mtvec_q   <= 32'h0;
            mepc_q    <= 32'h0;
            mstatus_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (take_trap || take_mret) begin
                pc_q      <= inst_addr_i;
                cause_q   <= cause_d;
                mtvec_q   <= mtvec_i;
                mepc_q    <= mepc_i;
                mstatus_q <= mstatus_i;
            end
        end
    end

endmodule
